// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_ctrl
//  Purpose  : Edge-capturing interrupt pending controller. Latches rising
//             edges of raw request lines into a pending register, masks the
//             pending vector toward an external priority encoder, registers
//             the returned index and presents it with a valid/ack handshake.
//             An ack clears the serviced pending bit. A saturating counter
//             tracks request edges lost because their bit was already pending.
//  Ports    : clk          - system clock, rising edge
//             reset_n      - asynchronous active-low reset
//             irq_in       - raw request lines (event = 0->1 transition)
//             mask_in      - per-line enable, 1 = enabled
//             pending_out  - pending & mask_in (combinational, to encoder)
//             enc_idx_in   - encoder result for pending_out
//             irq_valid    - registered, irq_idx holds a serviceable request
//             irq_idx      - registered index of the presented request
//             irq_ack      - consumer accepts the presented request
//             drop_cnt     - saturating count of lost edges
//  Options  : IRQ_PENDING_SYNC_EN - when defined, irq_in passes through a
//             2-flop synchroniser before edge detection (+2 cycles latency).
//  Revision : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
    parameter int NUM_IRQ   = 8,
    parameter int IDX_WIDTH = $clog2(NUM_IRQ),
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic [NUM_IRQ-1:0]   mask_in,
    output logic [NUM_IRQ-1:0]   pending_out,
    input  logic [IDX_WIDTH-1:0] enc_idx_in,
    output logic                 irq_valid,
    output logic [IDX_WIDTH-1:0] irq_idx,
    input  logic                 irq_ack,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    localparam logic [NUM_IRQ-1:0]   c_one_hot_lsb = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_IRQ-1:0]     w_irq;
    logic [NUM_IRQ-1:0]     r_irq_prev;
    logic [NUM_IRQ-1:0]     r_pending;
    logic [NUM_IRQ-1:0]     w_edge;
    logic [NUM_IRQ-1:0]     w_ack_clr;
    logic                   w_drop;
    logic                   r_valid;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [CNT_WIDTH-1:0]   r_drop_cnt;

`ifdef IRQ_PENDING_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = irq_in;
`endif

    assign w_edge = w_irq & ~r_irq_prev;

    // Only a handshake completed in PRESENT clears a bit; ack elsewhere is inert.
    assign w_ack_clr = (r_state == ST_PRESENT && irq_ack) ? (c_one_hot_lsb << r_idx) : '0;

    // A bit being cleared this cycle absorbs its new edge as a fresh event,
    // so it is not counted as lost.
    assign w_drop = |(w_edge & r_pending & ~w_ack_clr);

    assign pending_out = r_pending & mask_in;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (|pending_out) w_state_next = ST_PRESENT;
            ST_PRESENT: if (irq_ack)      w_state_next = ST_SETTLE;
            ST_SETTLE:                    w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_irq_prev <= w_irq;
            // Set after clear: a same-cycle edge wins over the ack.
            r_pending  <= (r_pending & ~w_ack_clr) | w_edge;
            r_valid    <= (w_state_next == ST_PRESENT);
            if (r_state == ST_IDLE && |pending_out) begin
                r_idx <= enc_idx_in;
            end
            if (w_drop && r_drop_cnt != c_cnt_max) begin
                r_drop_cnt <= r_drop_cnt + c_cnt_one;
            end
        end
    end

    assign irq_valid = r_valid;
    assign irq_idx   = r_idx;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
